pwm_seq_core: RTL and testbench

PWM_SEQ_CORE -- requirements
Module: pwm_seq_core

---
 rtl/pwm_seq_core.sv | 133 +++++++++++++
 tb/tb_pwm_seq_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq_core.sv
`default_nettype none
// ============================================================================
// pwm_seq_core : multi-channel phase-offset PWM with per-channel A/B blinking
// Revision     : 1.0
// ============================================================================
module pwm_seq_core #(
    parameter int NOutputs   = 6,
    parameter int PhaseCntDw = 16,
    parameter int BeatCntDw  = 27,
    parameter int BlinkCntDw = 16
) (
    input  logic                             clk_core_i,
    input  logic                             rst_core_ni,
    input  logic                             cntr_en_i,
    input  logic                             cfg_we_i,
    input  logic [BeatCntDw-1:0]             clk_div_i,
    input  logic [3:0]                       dc_resn_i,
    input  logic [NOutputs-1:0]              pwm_en_i,
    input  logic [NOutputs-1:0]              invert_i,
    input  logic [NOutputs-1:0]              blink_en_i,
    input  logic [NOutputs*PhaseCntDw-1:0]   phase_delay_i,
    input  logic [NOutputs*PhaseCntDw-1:0]   duty_a_i,
    input  logic [NOutputs*PhaseCntDw-1:0]   duty_b_i,
    input  logic [NOutputs*BlinkCntDw-1:0]   blink_x_i,
    input  logic [NOutputs*BlinkCntDw-1:0]   blink_y_i,
    output logic [NOutputs-1:0]              pwm_o,
    output logic                             cycle_end_o
);

    localparam logic [3:0] ResMax = 4'(PhaseCntDw - 1);

    typedef enum logic [0:0] {
        ST_A = 1'b0,
        ST_B = 1'b1
    } blink_state_t;

    logic [BeatCntDw-1:0]  beat;
    logic [PhaseCntDw-1:0] phase;
    logic [3:0]            res;
    logic [3:0]            shift;
    logic [PhaseCntDw-1:0] incr;
    logic [PhaseCntDw-1:0] mask;
    logic [PhaseCntDw:0]   phase_sum;
    logic                  beat_end;
    logic                  cycle_end;
    logic                  shadow_load;
    logic [NOutputs-1:0]   pwm_next;

    // Coarser resolutions step the phase by larger increments and ignore the low bits.
    assign res         = (dc_resn_i > ResMax) ? ResMax : dc_resn_i;
    assign shift       = ResMax - res;
    assign incr        = {{(PhaseCntDw-1){1'b0}}, 1'b1} << shift;
    assign mask        = {PhaseCntDw{1'b1}} << shift;
    assign beat_end    = (beat == clk_div_i);
    assign phase_sum   = {1'b0, phase} + {1'b0, incr};
    assign cycle_end   = beat_end & cntr_en_i & ~cfg_we_i & phase_sum[PhaseCntDw];
    assign cycle_end_o = cycle_end;
    assign shadow_load = cycle_end | cfg_we_i | ~cntr_en_i;

    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni) begin
            beat  <= '0;
            phase <= '0;
        end else if (cfg_we_i) begin
            beat  <= '0;
            phase <= '0;
        end else if (cntr_en_i) begin
            beat <= beat_end ? '0 : beat + BeatCntDw'(1);
            if (beat_end) begin
                phase <= phase_sum[PhaseCntDw-1:0];
            end
        end
    end

    for (genvar i = 0; i < NOutputs; i++) begin : g_ch
        logic [PhaseCntDw-1:0] duty_a_sh;
        logic [PhaseCntDw-1:0] duty_b_sh;
        logic [PhaseCntDw-1:0] delay_sh;
        logic [PhaseCntDw-1:0] duty;
        logic [PhaseCntDw-1:0] rel;
        logic [BlinkCntDw-1:0] cnt;
        blink_state_t          state;
        logic                  raw;

        // Shadows only move at cycle boundaries while running, so edits never tear a cycle.
        always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
            if (!rst_core_ni) begin
                duty_a_sh <= '0;
                duty_b_sh <= '0;
                delay_sh  <= '0;
            end else if (shadow_load) begin
                duty_a_sh <= duty_a_i[i*PhaseCntDw +: PhaseCntDw];
                duty_b_sh <= duty_b_i[i*PhaseCntDw +: PhaseCntDw];
                delay_sh  <= phase_delay_i[i*PhaseCntDw +: PhaseCntDw];
            end
        end

        always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
            if (!rst_core_ni) begin
                state <= ST_A;
                cnt   <= '0;
            end else if (cfg_we_i || !blink_en_i[i]) begin
                state <= ST_A;
                cnt   <= '0;
            end else if (cycle_end) begin
                if (state == ST_A && cnt == blink_x_i[i*BlinkCntDw +: BlinkCntDw]) begin
                    state <= ST_B;
                    cnt   <= '0;
                end else if (state == ST_B && cnt == blink_y_i[i*BlinkCntDw +: BlinkCntDw]) begin
                    state <= ST_A;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + BlinkCntDw'(1);
                end
            end
        end

        assign duty        = (blink_en_i[i] && state == ST_B) ? duty_b_sh : duty_a_sh;
        assign rel         = phase - delay_sh;
        assign raw         = ((duty & mask) == mask) ? 1'b1 : ((rel & mask) < (duty & mask));
        assign pwm_next[i] = pwm_en_i[i] ? (raw ^ invert_i[i]) : invert_i[i];
    end

    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni) begin
            pwm_o <= '0;
        end else begin
            pwm_o <= pwm_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_seq_core.sv
`default_nettype none
// ============================================================================
// tb_pwm_seq_core : directed self-checking bench for pwm_seq_core
// Revision        : 1.0
// ============================================================================
module tb_pwm_seq_core;

    localparam int N  = 6;
    localparam int PW = 16;
    localparam int BW = 27;
    localparam int LW = 16;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            cntr_en  = 1'b0;
    logic            cfg_we   = 1'b0;
    logic [BW-1:0]   clk_div  = '0;
    logic [3:0]      dc_resn  = 4'd3;
    logic [N-1:0]    pwm_en   = 6'b110111;
    logic [N-1:0]    invert   = 6'b001100;
    logic [N-1:0]    blink_en = '0;
    logic [N*PW-1:0] phase_delay = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000};
    logic [N*PW-1:0] duty_a      = {16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    logic [N*PW-1:0] duty_b      = '0;
    logic [N*LW-1:0] blink_x     = '0;
    logic [N*LW-1:0] blink_y     = '0;
    logic [N-1:0]    pwm;
    logic            cycle_end;

    logic            cntr_en8 = 1'b0;
    logic            cfg_we8  = 1'b0;
    logic [3:0]      clk_div8 = 4'd0;
    logic [0:0]      pwm8;
    logic            cycle_end8;

    int checks = 0;
    int errors = 0;
    int blink_exp [8] = '{4, 4, 12, 12, 12, 4, 4, 12};

    always #5 clk = ~clk;

    pwm_seq_core #(
        .NOutputs   (N),
        .PhaseCntDw (PW),
        .BeatCntDw  (BW),
        .BlinkCntDw (LW)
    ) dut (
        .clk_core_i    (clk),
        .rst_core_ni   (rst_n),
        .cntr_en_i     (cntr_en),
        .cfg_we_i      (cfg_we),
        .clk_div_i     (clk_div),
        .dc_resn_i     (dc_resn),
        .pwm_en_i      (pwm_en),
        .invert_i      (invert),
        .blink_en_i    (blink_en),
        .phase_delay_i (phase_delay),
        .duty_a_i      (duty_a),
        .duty_b_i      (duty_b),
        .blink_x_i     (blink_x),
        .blink_y_i     (blink_y),
        .pwm_o         (pwm),
        .cycle_end_o   (cycle_end)
    );

    pwm_seq_core #(
        .NOutputs   (1),
        .PhaseCntDw (8),
        .BeatCntDw  (4),
        .BlinkCntDw (4)
    ) dut8 (
        .clk_core_i    (clk),
        .rst_core_ni   (rst_n),
        .cntr_en_i     (cntr_en8),
        .cfg_we_i      (cfg_we8),
        .clk_div_i     (clk_div8),
        .dc_resn_i     (4'd15),
        .pwm_en_i      (1'b1),
        .invert_i      (1'b0),
        .blink_en_i    (1'b0),
        .phase_delay_i (8'h00),
        .duty_a_i      (8'h80),
        .duty_b_i      (8'h00),
        .blink_x_i     (4'h0),
        .blink_y_i     (4'h0),
        .pwm_o         (pwm8),
        .cycle_end_o   (cycle_end8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Per-cycle patterns, MSB first; ch3 is always 1 and ch5 always 0 in these scenarios.
    task automatic wave(input string tag, input int n, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p4, input logic [31:0] pce);
        for (int i = 0; i < n; i++) begin
            int b;
            b = n - 1 - i;
            step();
            check($sformatf("%s pwm @%0d", tag, i), 32'(pwm),
                  32'({1'b0, p4[b], 1'b1, p2[b], p1[b], p0[b]}));
            check($sformatf("%s cycle_end @%0d", tag, i), 32'(cycle_end), 32'(pce[b]));
        end
    endtask

    task automatic count_window(input int n, output int hi, output int ce_n);
        hi   = 0;
        ce_n = 0;
        for (int i = 0; i < n; i++) begin
            step();
            hi   += int'(pwm[0]);
            ce_n += int'(cycle_end);
        end
    endtask

    task automatic cfg_pulse();
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int hi, ce_n, ce_idx, low_idx;

        repeat (2) step();
        check("reset pwm", 32'(pwm), 32'h0);
        check("reset cycle_end", 32'(cycle_end), 32'h0);
        check("reset pwm8", 32'(pwm8), 32'h0);

        rst_n = 1'b1;
        repeat (2) step();
        check("frozen pwm", 32'(pwm), 32'(6'b011001));
        check("frozen pwm8", 32'(pwm8), 32'h1);
        repeat (3) step();
        check("frozen hold pwm", 32'(pwm), 32'(6'b011001));
        check("frozen cycle_end", 32'(cycle_end), 32'h0);

        cntr_en = 1'b1;
        cfg_pulse();
        check("start pwm", 32'(pwm), 32'(6'b011001));
        check("start cycle_end", 32'(cycle_end), 32'h0);
        wave("base", 32, 32'hFF00FF00, 32'h0FF00FF0, 32'h00FF00FF, 32'hFFFFFFFF, 32'h00020002);

        repeat (4) step();
        duty_a[0 +: PW] = 16'h4000;
        wave("dutychg", 32, 32'hF00F000F, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFFFFFFF, 32'h00200020);

        blink_en[0]      = 1'b1;
        blink_x[0 +: LW] = 16'd1;
        blink_y[0 +: LW] = 16'd2;
        duty_b[0 +: PW]  = 16'hC000;
        cfg_pulse();
        for (int c = 0; c < 8; c++) begin
            count_window(16, hi, ce_n);
            check($sformatf("blink high c%0d", c), 32'(hi), 32'(blink_exp[c]));
            check($sformatf("blink cycle_end c%0d", c), 32'(ce_n), 32'd1);
        end

        // cfg write landing on the cycle end: blink must restart in A
        repeat (15) step();
        check("pre-coincident cycle_end", 32'(cycle_end), 32'h1);
        cfg_we = 1'b1;
        #1;
        check("coincident cycle_end masked", 32'(cycle_end), 32'h0);
        step();
        cfg_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            count_window(16, hi, ce_n);
            check($sformatf("coinc high c%0d", c), 32'(hi), 32'(blink_exp[c]));
        end

        repeat (5) step();
        cfg_pulse();
        count_window(16, hi, ce_n);
        check("midcfg high", 32'(hi), 32'd4);
        check("midcfg cycle_end", 32'(ce_n), 32'd1);

        repeat (6) step();
        check("pre-reset ch4", 32'(pwm[4]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async reset pwm", 32'(pwm), 32'h0);
        check("async reset cycle_end", 32'(cycle_end), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        wave("postrst", 17, 32'h00001, 32'h00000, 32'h1FFFE, 32'h00001, 32'h00004);

        blink_en[0] = 1'b0;
        clk_div     = 27'd1;
        cfg_pulse();
        for (int c = 0; c < 2; c++) begin
            count_window(32, hi, ce_n);
            check($sformatf("div1 high c%0d", c), 32'(hi), 32'd8);
            check($sformatf("div1 cycle_end c%0d", c), 32'(ce_n), 32'd1);
        end

        cntr_en8 = 1'b1;
        hi       = 0;
        ce_n     = 0;
        ce_idx   = -1;
        low_idx  = -1;
        for (int i = 0; i < 256; i++) begin
            step();
            if (pwm8[0]) hi++;
            else if (low_idx < 0) low_idx = i;
            if (cycle_end8) begin
                ce_n++;
                ce_idx = i;
            end
        end
        check("res clamp high count", 32'(hi), 32'd128);
        check("res clamp first low", 32'(low_idx), 32'd128);
        check("res clamp cycle_end count", 32'(ce_n), 32'd1);
        check("res clamp cycle_end index", 32'(ce_idx), 32'd254);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
